// File: rtl/rv_mc_ctrl_if.sv
// Shared memory-port handshake between the multi-cycle sequencer and the memory.
// The master side raises the request; the slave side answers with MEM_ACK.
interface rv_mc_ctrl_if;
    logic MEM_REQ;
    logic MEM_SEL;
    logic MEM_WE;
    logic MEM_ACK;

    modport master (output MEM_REQ, output MEM_SEL, output MEM_WE, input MEM_ACK);
    modport slave  (input MEM_REQ, input MEM_SEL, input MEM_WE, output MEM_ACK);
endinterface

// File: rtl/rv_mc_ctrl.sv
// Multi-cycle RV32I sequencer: IDLE/FETCH/DECODE/EXEC/MEM/WB with retire counter.
// Optional macro MC_CTRL_ILLEGAL_TRAP_EN sends unknown opcodes to a sticky TRAP state.
module rv_mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RUN,
    input  logic [6:0]       OPCODE,
    input  logic             BR_TAKEN,
    rv_mc_ctrl_if.master     mem,
    output logic             IR_WE,
    output logic             RF_WE,
    output logic             PC_WE,
    output logic             PC_SEL,
    output logic [3:0]       ALU_INST,
    output logic             RETIRE,
    output logic [CNT_W-1:0] RETIRE_CNT,
    output logic             ILLEGAL,
    output logic [2:0]       STATE
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [3:0] C_LUI   = 4'd0;
    localparam logic [3:0] C_AUIPC = 4'd1;
    localparam logic [3:0] C_JAL   = 4'd2;
    localparam logic [3:0] C_JALR  = 4'd3;
    localparam logic [3:0] C_STORE = 4'd4;
    localparam logic [3:0] C_LOAD  = 4'd5;
    localparam logic [3:0] C_OPIMM = 4'd6;
    localparam logic [3:0] C_BR    = 4'd7;
    localparam logic [3:0] C_OP    = 4'd8;
    // Not a real class: marks an unrecognised opcode travelling through as a NOP.
    localparam logic [3:0] C_ILL   = 4'd15;

    function automatic logic [3:0] decode_class(input logic [6:0] op);
        case (op)
            7'b0110111: decode_class = C_LUI;
            7'b0010111: decode_class = C_AUIPC;
            7'b1101111: decode_class = C_JAL;
            7'b1100111: decode_class = C_JALR;
            7'b0100011: decode_class = C_STORE;
            7'b0000011: decode_class = C_LOAD;
            7'b0010011: decode_class = C_OPIMM;
            7'b1100011: decode_class = C_BR;
            7'b0110011: decode_class = C_OP;
            default:    decode_class = C_ILL;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       alu_inst_q, alu_inst_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic             illegal_q, illegal_d;
`endif

    always_comb begin
        state_d     = state_q;
        alu_inst_d  = alu_inst_q;
        cnt_d       = cnt_q;
        mem.MEM_REQ = 1'b0;
        mem.MEM_SEL = 1'b0;
        mem.MEM_WE  = 1'b0;
        IR_WE       = 1'b0;
        RF_WE       = 1'b0;
        PC_WE       = 1'b0;
        PC_SEL      = 1'b0;
        retire      = 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        illegal_d   = illegal_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (RUN) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem.MEM_REQ = 1'b1;
                if (mem.MEM_ACK) begin
                    IR_WE   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_inst_d = decode_class(OPCODE);
                state_d    = S_EXEC;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                if (decode_class(OPCODE) == C_ILL) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
`endif
            end
            S_EXEC: begin
                if (alu_inst_q == C_BR) begin
                    PC_WE  = 1'b1;
                    PC_SEL = BR_TAKEN;
                    retire = 1'b1;
                end else if (alu_inst_q == C_STORE || alu_inst_q == C_LOAD) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem.MEM_REQ = 1'b1;
                mem.MEM_SEL = 1'b1;
                mem.MEM_WE  = (alu_inst_q == C_STORE);
                if (mem.MEM_ACK) begin
                    if (alu_inst_q == C_STORE) begin
                        PC_WE  = 1'b1;
                        retire = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                RF_WE  = (alu_inst_q != C_ILL);
                PC_WE  = 1'b1;
                PC_SEL = (alu_inst_q == C_JAL) || (alu_inst_q == C_JALR);
                retire = 1'b1;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // RUN only matters at an instruction boundary, and only for the next state.
        if (retire) begin
            state_d = RUN ? S_FETCH : S_IDLE;
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            alu_inst_q <= 4'd0;
            cnt_q      <= '0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            illegal_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            alu_inst_q <= alu_inst_d;
            cnt_q      <= cnt_d;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            illegal_q  <= illegal_d;
`endif
        end
    end

    assign RETIRE     = retire;
    assign ALU_INST   = alu_inst_q;
    assign RETIRE_CNT = cnt_q;
    assign STATE      = state_q;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign ILLEGAL    = illegal_q;
`else
    assign ILLEGAL    = 1'b0;
`endif

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Directed bench for rv_mc_ctrl: per-instruction vector table plus hand-written
// sequences for run-stop, illegal opcode, reset mid-request and counter wrap.
module tb_rv_mc_ctrl;

    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             RST;
    logic             RUN;
    logic [6:0]       OPCODE;
    logic             BR_TAKEN;
    logic             IR_WE, RF_WE, PC_WE, PC_SEL, RETIRE, ILLEGAL;
    logic [3:0]       ALU_INST;
    logic [CNT_W-1:0] RETIRE_CNT;
    logic [2:0]       STATE;

    rv_mc_ctrl_if mif ();

    rv_mc_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .RUN(RUN), .OPCODE(OPCODE), .BR_TAKEN(BR_TAKEN),
        .mem(mif), .IR_WE(IR_WE), .RF_WE(RF_WE), .PC_WE(PC_WE), .PC_SEL(PC_SEL),
        .ALU_INST(ALU_INST), .RETIRE(RETIRE), .RETIRE_CNT(RETIRE_CNT),
        .ILLEGAL(ILLEGAL), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [6:0] op;
        logic       br;
        int         fw;
        int         mw;
        int         cyc;
        int         alu;
        int         rf;
        int         mwe;
        int         mcyc;
        int         psel;
    } vec_t;

    vec_t tbl [12];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " STATE"},      STATE, 0);
        chk({tag, " MEM_REQ"},    mif.MEM_REQ, 0);
        chk({tag, " MEM_SEL"},    mif.MEM_SEL, 0);
        chk({tag, " MEM_WE"},     mif.MEM_WE, 0);
        chk({tag, " IR_WE"},      IR_WE, 0);
        chk({tag, " RF_WE"},      RF_WE, 0);
        chk({tag, " PC_WE"},      PC_WE, 0);
        chk({tag, " PC_SEL"},     PC_SEL, 0);
        chk({tag, " RETIRE"},     RETIRE, 0);
        chk({tag, " RETIRE_CNT"}, RETIRE_CNT, 0);
        chk({tag, " ILLEGAL"},    ILLEGAL, 0);
        chk({tag, " ALU_INST"},   ALU_INST, 0);
    endtask

    // Runs one instruction; memory answers after fw/mw wait cycles. Returns on the retire cycle.
    task automatic run_instr(input logic [6:0] op, input logic br, input int fw, input int mw,
                             input bit drop_run, output int cyc, output int alu, output int rf,
                             output int mwe, output int mcyc, output int psel, output int pwe);
        int  waitc = 0;
        bit  done  = 0;
        cyc = 0; alu = -1; rf = 0; mwe = 0; mcyc = 0; psel = -1; pwe = -1;
        OPCODE = op;
        BR_TAKEN = br;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge CLK);
            if (mif.MEM_REQ) begin
                int need;
                need = mif.MEM_SEL ? mw : fw;
                mif.MEM_ACK = (waitc >= need);
                waitc = mif.MEM_ACK ? 0 : waitc + 1;
            end else begin
                mif.MEM_ACK = 1'b0;
                waitc = 0;
            end
            #1;
            if (STATE != 3'd0) cyc++;
            if (STATE == 3'd3) begin
                alu = int'(ALU_INST);
                if (drop_run) RUN = 1'b0;
            end
            if (RF_WE) rf++;
            if (mif.MEM_WE) mwe++;
            if (mif.MEM_REQ && mif.MEM_SEL) mcyc++;
            if (RETIRE) begin
                psel = int'(PC_SEL);
                pwe  = int'(PC_WE);
                done = 1;
            end
        end
        if (!done) chk("retire timeout", 0, 1);
    endtask

    initial begin
        int cyc, alu, rf, mwe, mcyc, psel, pwe;
        tbl[0]  = '{7'b0110011, 1'b0, 0, 0, 4, 8, 1, 0, 0, 0};
        tbl[1]  = '{7'b0010011, 1'b0, 0, 0, 4, 6, 1, 0, 0, 0};
        tbl[2]  = '{7'b0110111, 1'b0, 0, 0, 4, 0, 1, 0, 0, 0};
        tbl[3]  = '{7'b0010111, 1'b0, 0, 0, 4, 1, 1, 0, 0, 0};
        tbl[4]  = '{7'b1101111, 1'b0, 0, 0, 4, 2, 1, 0, 0, 1};
        tbl[5]  = '{7'b1100111, 1'b0, 0, 0, 4, 3, 1, 0, 0, 1};
        tbl[6]  = '{7'b0100011, 1'b0, 0, 0, 4, 4, 0, 1, 1, 0};
        tbl[7]  = '{7'b0000011, 1'b0, 0, 2, 7, 5, 1, 0, 3, 0};
        tbl[8]  = '{7'b1100011, 1'b1, 0, 0, 3, 7, 0, 0, 0, 1};
        tbl[9]  = '{7'b1100011, 1'b0, 0, 0, 3, 7, 0, 0, 0, 0};
        tbl[10] = '{7'b0110011, 1'b0, 2, 0, 6, 8, 1, 0, 0, 0};
        tbl[11] = '{7'b0100011, 1'b0, 1, 1, 6, 4, 0, 2, 2, 0};

        RST = 1'b1; RUN = 1'b0; OPCODE = 7'd0; BR_TAKEN = 1'b0; mif.MEM_ACK = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1 chk_idle("reset");

        // Acks with no request outstanding must not move the FSM.
        mif.MEM_ACK = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        chk("idle stray ack STATE", STATE, 0);
        chk("idle stray ack IR_WE", IR_WE, 0);
        mif.MEM_ACK = 1'b0;

        RUN = 1'b1;
        for (int v = 0; v < 12; v++) begin
            run_instr(tbl[v].op, tbl[v].br, tbl[v].fw, tbl[v].mw, 1'b0,
                      cyc, alu, rf, mwe, mcyc, psel, pwe);
            chk($sformatf("v%0d cycles", v), cyc, tbl[v].cyc);
            chk($sformatf("v%0d ALU_INST", v), alu, tbl[v].alu);
            chk($sformatf("v%0d RF_WE cycles", v), rf, tbl[v].rf);
            chk($sformatf("v%0d MEM_WE cycles", v), mwe, tbl[v].mwe);
            chk($sformatf("v%0d data req cycles", v), mcyc, tbl[v].mcyc);
            chk($sformatf("v%0d PC_SEL", v), psel, tbl[v].psel);
            chk($sformatf("v%0d PC_WE", v), pwe, 1);
            chk($sformatf("v%0d RETIRE_CNT", v), RETIRE_CNT, exp_cnt);
            exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        end

        // Store with RUN dropped in EXEC: retires, then parks in IDLE.
        run_instr(7'b0100011, 1'b0, 0, 0, 1'b1, cyc, alu, rf, mwe, mcyc, psel, pwe);
        chk("sw stop cycles", cyc, 4);
        chk("sw stop PC_WE", pwe, 1);
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        @(negedge CLK);
        mif.MEM_ACK = 1'b0;
        #1;
        chk("sw stop STATE idle", STATE, 0);
        chk("sw stop RETIRE_CNT", RETIRE_CNT, exp_cnt);
        @(negedge CLK);
        #1 chk("sw stop still idle", STATE, 0);

        RUN = 1'b1;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        begin
            int rets = 0;
            OPCODE = 7'b1111111;
            for (int i = 0; i < 12; i++) begin
                @(negedge CLK);
                mif.MEM_ACK = mif.MEM_REQ;
                #1;
                if (RETIRE) rets++;
            end
            chk("illegal STATE trap", STATE, 6);
            chk("illegal ILLEGAL", ILLEGAL, 1);
            chk("illegal no retire", rets, 0);
            chk("illegal RETIRE_CNT", RETIRE_CNT, exp_cnt);
        end
`else
        run_instr(7'b1111111, 1'b0, 0, 0, 1'b0, cyc, alu, rf, mwe, mcyc, psel, pwe);
        chk("nop cycles", cyc, 4);
        chk("nop RF_WE cycles", rf, 0);
        chk("nop PC_WE", pwe, 1);
        chk("nop PC_SEL", psel, 0);
        chk("nop ILLEGAL", ILLEGAL, 0);
        chk("nop RETIRE_CNT", RETIRE_CNT, exp_cnt);
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        RUN = 1'b0;
        @(negedge CLK);
        mif.MEM_ACK = 1'b0;
        #1 chk("nop RETIRE_CNT after", RETIRE_CNT, exp_cnt);
`endif

        // Reset while a data request is outstanding; also first-fetch latency from IDLE.
        RST = 1'b1; RUN = 1'b0; mif.MEM_ACK = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        #1 chk("pre-run STATE", STATE, 0);
        RUN = 1'b1;
        OPCODE = 7'b0000011;
        @(negedge CLK);
        #1;
        chk("first fetch STATE", STATE, 1);
        chk("first fetch MEM_REQ", mif.MEM_REQ, 1);
        chk("first fetch MEM_SEL", mif.MEM_SEL, 0);
        mif.MEM_ACK = 1'b1;
        #1 chk("first fetch IR_WE", IR_WE, 1);
        @(negedge CLK);
        mif.MEM_ACK = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        chk("lw held STATE", STATE, 4);
        chk("lw held MEM_REQ", mif.MEM_REQ, 1);
        chk("lw held MEM_SEL", mif.MEM_SEL, 1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        RUN = 1'b0;
        #1 chk_idle("reset in MEM");
        exp_cnt = 0;

        // Counter wrap: sixteen branches from zero.
        RUN = 1'b1;
        for (int i = 0; i < 16; i++) begin
            run_instr(7'b1100011, 1'b0, 0, 0, 1'b0, cyc, alu, rf, mwe, mcyc, psel, pwe);
            if (i == 15) RUN = 1'b0;
            chk($sformatf("wrap %0d RETIRE_CNT", i), RETIRE_CNT, exp_cnt);
            exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        end
        @(negedge CLK);
        mif.MEM_ACK = 1'b0;
        #1;
        chk("wrap RETIRE_CNT zero", RETIRE_CNT, 0);
        chk("wrap STATE idle", STATE, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got 0, expected 1");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rv_mc_ctrl.md
# rv_mc_ctrl

Multi-cycle sequencer for the RV32I core. It steps each instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB, issues the 4-bit instruction-class code consumed by the ALU control decoder, and drives the register-file, PC and IR write enables. It also owns the shared memory port handshake and a retired-instruction counter. It sits between the instruction register / memory interface and the datapath write strobes.

## Interface
- CNT_W, 32, width of retired-instruction counter
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- RUN  in  1  level; 1 = execute, 0 = stop at next instruction boundary
- OPCODE  in  7  INST[6:0] from the instruction register, valid from DECODE onward
- BR_TAKEN  in  1  branch comparison result from the ALU, sampled in EXEC
- MEM_ACK  in  1  memory completion, same-cycle response allowed
- MEM_REQ  out  1  memory request, held until MEM_ACK
- MEM_SEL  out  1  0 = instruction fetch, 1 = data access
- MEM_WE  out  1  data write (stores only)
- IR_WE  out  1  load the instruction register
- RF_WE  out  1  register-file write
- PC_WE  out  1  PC update
- PC_SEL  out  1  0 = PC+4, 1 = ALU target
- ALU_INST  out  4  class code: 0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 S, 5 LOAD, 6 I-ALU, 7 SB, 8 R
- RETIRE  out  1  one-cycle pulse per completed instruction
- RETIRE_CNT  out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W
- ILLEGAL  out  1  sticky illegal-opcode flag (macro only, otherwise tied 0)
- STATE  out  3  current state, for debug

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- IDLE: all strobes 0. Goes to FETCH when RUN=1.
- FETCH: MEM_REQ=1 and MEM_SEL=0. When MEM_ACK=1 in the same cycle, IR_WE=1 and the next state is DECODE. Otherwise the FSM stays in FETCH with the request held.
- DECODE: maps OPCODE to a class and registers ALU_INST.
  - LUI 0110111=0, AUIPC 0010111=1, JAL 1101111=2, JALR 1100111=3, STORE 0100011=4, LOAD 0000011=5, OP-IMM 0010011=6, BRANCH 1100011=7, OP 0110011=8.
  - Next state is always EXEC, except for an illegal opcode (see Configuration).
- EXEC: ALU_INST is held stable.
  - Class 7: PC_WE=1, PC_SEL=BR_TAKEN, RETIRE=1, instruction ends.
  - Classes 4 and 5: next state is MEM.
  - All others: next state is WB.
- MEM: MEM_REQ=1, MEM_SEL=1, MEM_WE=(class 4). The FSM waits for MEM_ACK.
  - On ack for a store: PC_WE=1, PC_SEL=0, RETIRE=1, instruction ends.
  - On ack for a load: next state is WB.
- WB: RF_WE=1 and PC_WE=1. PC_SEL=1 for classes 2 and 3, 0 otherwise. RETIRE=1, instruction ends.
- Instruction end: next state is FETCH if RUN=1, IDLE if RUN=0. RUN is only sampled at ends and in IDLE.
- RETIRE_CNT increments by 1 on every RETIRE and wraps from all-ones to 0.
- MEM_ACK while MEM_REQ=0 is ignored.

## Timing
- Reset (RST=1 at an edge, any state, including mid-request):
  - State goes to IDLE.
  - Every output goes to 0: MEM_REQ, MEM_SEL, MEM_WE, IR_WE, RF_WE, PC_WE, PC_SEL, RETIRE, RETIRE_CNT, ILLEGAL, and ALU_INST=4'd0.
  - Any outstanding request is abandoned.
- Strobes are Moore/Mealy on current state plus MEM_ACK and BR_TAKEN only. There is no combinational path from RUN to outputs.
- Cycles per instruction with zero-wait memory (MEM_ACK=1 on the first request cycle):
  - Branch: 3.
  - R, I-ALU, LUI, AUIPC, JAL, JALR, store: 4.
  - Load: 5.
- Each wait cycle on MEM_ACK adds exactly 1 cycle.
- First FETCH request is 1 cycle after RUN is sampled high in IDLE.

## Configuration
- MC_CTRL_ILLEGAL_TRAP_EN defined:
  - An unrecognised OPCODE in DECODE goes to TRAP and sets ILLEGAL=1.
  - TRAP holds all strobes 0, RETIRE is not asserted, and TRAP is left only by RST.
- Not defined:
  - An unrecognised opcode is executed as a NOP: EXEC, then WB with RF_WE=0, PC_WE=1, PC_SEL=0, RETIRE=1.
  - ILLEGAL is tied 0 and TRAP is unreachable.

## Test plan
- ADD (0110011), RUN=1, MEM_ACK always 1 -> states 1,2,3,5. ALU_INST=8 from EXEC. RF_WE and PC_WE pulse in cycle 4 with PC_SEL=0. RETIRE_CNT=1.
- LW (0000011) with MEM_ACK delayed 2 cycles in MEM -> MEM_REQ=1, MEM_SEL=1, MEM_WE=0 for 3 cycles. Then WB. Total 7 cycles.
- BEQ (1100011) with BR_TAKEN=1, then again with 0 -> 3 cycles each. PC_SEL=1 then 0. RF_WE never asserted.
- SW (0100011) -> MEM_WE=1 in MEM, PC_WE=1 on ack, no WB state. Also: RUN dropped during EXEC -> FSM enters IDLE after the store retires.
- Opcode 7'b1111111 -> with the macro: TRAP, ILLEGAL=1, no RETIRE. Without the macro: NOP retires, RETIRE_CNT increments.
- RST asserted in MEM with MEM_REQ=1 -> next cycle IDLE, all outputs 0, RETIRE_CNT=0. Separately: preload RETIRE_CNT to 32'hFFFFFFFF, retire one instruction -> RETIRE_CNT=0.
